// File: rtl/apb_gpio_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : apb_gpio_pkg
// Brief    : Shared types and register offsets for the APB GPIO completer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package apb_gpio_pkg;

    // Bus-side transfer state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } gpio_state_t;

    // Word offsets decoded from pADDR[3:2]
    localparam logic [1:0] GPIO_LED_OFS  = 2'd0;
    localparam logic [1:0] GPIO_SW_OFS   = 2'd1;
    localparam logic [1:0] GPIO_EDGE_OFS = 2'd2;
    localparam logic [1:0] GPIO_RSV_OFS  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/apb_gpio_slave_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : apb_gpio_slave_if
// Brief    : APB bus bundle between a requester and the GPIO completer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface apb_gpio_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] pADDR;
    logic          pSELx;
    logic          pENABLE;
    logic          pWRITE;
    logic [DW-1:0] pWDATA;
    logic [DW-1:0] pRDATA;
    logic          pREADY;
    logic          pSLVERR;

    modport master (
        output pADDR, pSELx, pENABLE, pWRITE, pWDATA,
        input  pRDATA, pREADY, pSLVERR
    );

    modport slave (
        input  pADDR, pSELx, pENABLE, pWRITE, pWDATA,
        output pRDATA, pREADY, pSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gpio_sync_edge
// Brief    : Two-flop synchronizer for asynchronous switches followed by a
//            rising-edge detector on the synchronized value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module gpio_sync_edge #(
    parameter int N = 16
) (
    input  wire          clk,
    input  wire          rst,
    input  wire  [N-1:0] i_async,
    output logic [N-1:0] o_sync,
    output logic [N-1:0] o_edge
);
    logic [N-1:0] r_meta;
    logic [N-1:0] r_sync;
    logic [N-1:0] r_sync_d;

    // Synchronizer chain plus one delayed copy for edge comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_sync & ~r_sync_d;
endmodule
`default_nettype wire

// File: rtl/apb_gpio_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : apb_gpio_slave
// Brief    : APB completer exposing LEDs (RW), switches (RO) and sticky
//            switch rising-edge flags (RW1C) with programmable wait states.
//            Optional macro APB_GPIO_PSLVERR_EN enables the error response
//            for reserved-offset accesses and writes to the switch register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module apb_gpio_slave #(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int N_GPIO      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  wire               pCLK,
    input  wire               pRESET,
    apb_gpio_slave_if.slave   bus,
    input  wire  [N_GPIO-1:0] switch,
    output logic [N_GPIO-1:0] led
);
    import apb_gpio_pkg::*;

    localparam int c_WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    gpio_state_t       r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [1:0]        r_addr;
    logic              r_write;
    logic [N_GPIO-1:0] r_wdata;
    logic [N_GPIO-1:0] r_led, r_edge;
    logic [N_GPIO-1:0] w_sync, w_edge_pulse, w_clr;
    logic              w_setup, w_load, w_commit, w_enter_done;
    logic [1:0]        w_ofs;
    logic [DW-1:0]     w_rd_val, r_prdata;
    logic              r_pready;
    logic [AW+DW-1:0]  w_unused_bits;

    // Only pADDR[3:2] and the low N_GPIO write bits carry meaning here
    assign w_unused_bits = {bus.pADDR, bus.pWDATA};

    gpio_sync_edge #(.N(N_GPIO)) u_sync_edge (
        .clk     (pCLK),
        .rst     (pRESET),
        .i_async (switch),
        .o_sync  (w_sync),
        .o_edge  (w_edge_pulse)
    );

    assign w_setup = bus.pSELx & ~bus.pENABLE;

    // Next-state, wait counter and transfer control decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_load = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(c_WAIT_INIT);
                    end
                end
            end
            WAIT: begin
                if (!bus.pSELx) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_commit    = bus.pSELx & bus.pENABLE & r_write;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The offset is still on the bus in IDLE (zero-wait entry into DONE)
    assign w_ofs        = (r_state == IDLE) ? bus.pADDR[3:2] : r_addr;
    assign w_enter_done = (w_state_nxt == DONE);

    // Register read mux; unimplemented bits read zero
    always_comb begin
        w_rd_val = '0;
        case (w_ofs)
            GPIO_LED_OFS:  w_rd_val[N_GPIO-1:0] = r_led;
            GPIO_SW_OFS:   w_rd_val[N_GPIO-1:0] = w_sync;
            GPIO_EDGE_OFS: w_rd_val[N_GPIO-1:0] = r_edge;
            default:       w_rd_val = '0;
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request during its setup phase
    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            r_addr  <= 2'd0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_load) begin
            r_addr  <= bus.pADDR[3:2];
            r_write <= bus.pWRITE;
            r_wdata <= bus.pWDATA[N_GPIO-1:0];
        end
    end

    // Registered response: ready pulse, read data held until the next DONE
    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            r_pready <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_pready <= w_enter_done;
            if (w_enter_done) begin
                r_prdata <= w_rd_val;
            end
        end
    end

    assign w_clr = (w_commit && r_addr == GPIO_EDGE_OFS) ? r_wdata : '0;

    // LED and edge-flag state; a new edge beats a same-cycle clear
    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            r_led  <= '0;
            r_edge <= '0;
        end else begin
            if (w_commit && r_addr == GPIO_LED_OFS) begin
                r_led <= r_wdata;
            end
            r_edge <= (r_edge & ~w_clr) | w_edge_pulse;
        end
    end

`ifdef APB_GPIO_PSLVERR_EN
    logic w_wr_sel;
    logic w_err;
    logic r_pslverr;

    assign w_wr_sel = (r_state == IDLE) ? bus.pWRITE : r_write;
    assign w_err    = (w_ofs == GPIO_RSV_OFS) | (w_wr_sel & (w_ofs == GPIO_SW_OFS));

    // Error flag accompanies the ready pulse
    always_ff @(posedge pCLK or posedge pRESET) begin
        if (pRESET) begin
            r_pslverr <= 1'b0;
        end else begin
            r_pslverr <= w_enter_done & w_err;
        end
    end

    assign bus.pSLVERR = r_pslverr;
`else
    assign bus.pSLVERR = 1'b0;
`endif

    assign bus.pREADY = r_pready;
    assign bus.pRDATA = r_prdata;
    assign led        = r_led;
endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_slave.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_apb_gpio_slave
// Brief    : Self-checking bench for apb_gpio_slave: a zero-wait and a
//            three-wait instance share the switch inputs and are compared
//            against a behavioural register model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_apb_gpio_slave;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int N    = 16;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] sw_in = '0;
    logic [N-1:0] led0, led3;

    apb_gpio_slave_if #(.AW(AW), .DW(DW)) bus0 ();
    apb_gpio_slave_if #(.AW(AW), .DW(DW)) bus3 ();

    logic          t_sel   [NDUT];
    logic          t_en    [NDUT];
    logic          t_wr    [NDUT];
    logic [AW-1:0] t_addr  [NDUT];
    logic [DW-1:0] t_wdata [NDUT];
    logic          o_ready [NDUT];
    logic [DW-1:0] o_rdata [NDUT];
    logic          o_err   [NDUT];
    logic [N-1:0]  o_led   [NDUT];

    assign bus0.pSELx   = t_sel[0];
    assign bus0.pENABLE = t_en[0];
    assign bus0.pWRITE  = t_wr[0];
    assign bus0.pADDR   = t_addr[0];
    assign bus0.pWDATA  = t_wdata[0];
    assign bus3.pSELx   = t_sel[1];
    assign bus3.pENABLE = t_en[1];
    assign bus3.pWRITE  = t_wr[1];
    assign bus3.pADDR   = t_addr[1];
    assign bus3.pWDATA  = t_wdata[1];
    assign o_ready[0] = bus0.pREADY;
    assign o_rdata[0] = bus0.pRDATA;
    assign o_err[0]   = bus0.pSLVERR;
    assign o_led[0]   = led0;
    assign o_ready[1] = bus3.pREADY;
    assign o_rdata[1] = bus3.pRDATA;
    assign o_err[1]   = bus3.pSLVERR;
    assign o_led[1]   = led3;

    apb_gpio_slave #(.DW(DW), .AW(AW), .N_GPIO(N), .WAIT_CYCLES(0)) u_dut0 (
        .pCLK(clk), .pRESET(rst), .bus(bus0), .switch(sw_in), .led(led0)
    );
    apb_gpio_slave #(.DW(DW), .AW(AW), .N_GPIO(N), .WAIT_CYCLES(3)) u_dut3 (
        .pCLK(clk), .pRESET(rst), .bus(bus3), .switch(sw_in), .led(led3)
    );

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference model: switch samples are seen two clocks later as the
    // synchronized value; a rise there latches a flag one clock after that.
    logic [N-1:0] hist        [4];
    logic [N-1:0] m_sync_prev;
    logic [N-1:0] m_edge      [NDUT];
    logic [N-1:0] m_edge_prev [NDUT];
    logic [N-1:0] m_clr       [NDUT];
    logic [N-1:0] m_led       [NDUT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            m_sync_prev <= '0;
            for (int d = 0; d < NDUT; d++) begin
                m_edge[d]      <= '0;
                m_edge_prev[d] <= '0;
            end
        end else begin
            hist[0] <= sw_in;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            m_sync_prev <= hist[1];
            for (int d = 0; d < NDUT; d++) begin
                m_edge_prev[d] <= m_edge[d];
                m_edge[d]      <= (m_edge[d] & ~m_clr[d]) | (hist[1] & ~hist[2]);
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // One APB transfer; starts immediately (caller sits just after an edge)
    // and returns just after the edge that ends the completing cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        t_sel[d] = 1'b1; t_en[d] = 1'b0; t_wr[d] = wr;
        t_addr[d] = addr; t_wdata[d] = wdata;
        @(posedge clk); #1;
        t_en[d] = 1'b1;
        lat = 1;
        while (!o_ready[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ready_seen", 32'(o_ready[d]), 32'd1);
        check("latency", lat, 1 + waits(d));
        case (addr[3:2])
            2'd0:    exp_rd = 32'(m_led[d]);
            2'd1:    exp_rd = 32'(m_sync_prev);
            2'd2:    exp_rd = 32'(m_edge_prev[d]);
            default: exp_rd = 32'd0;
        endcase
`ifdef APB_GPIO_PSLVERR_EN
        exp_err = (addr[3:2] == 2'd3) || (wr && addr[3:2] == 2'd1);
`else
        exp_err = 1'b0;
`endif
        rdata = o_rdata[d];
        check("rdata", rdata, exp_rd);
        check("pslverr", 32'(o_err[d]), 32'(exp_err));
        if (wr && addr[3:2] == 2'd2) m_clr[d] = wdata[N-1:0];
        @(posedge clk); #1;
        m_clr[d] = '0;
        if (wr && addr[3:2] == 2'd0) m_led[d] = wdata[N-1:0];
        t_sel[d] = 1'b0; t_en[d] = 1'b0;
        check("ready_one_cycle", 32'(o_ready[d]), 32'd0);
        check("led", 32'(o_led[d]), 32'(m_led[d]));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        seen;
        for (int d = 0; d < NDUT; d++) begin
            t_sel[d] = 1'b0; t_en[d] = 1'b0; t_wr[d] = 1'b0;
            t_addr[d] = '0; t_wdata[d] = '0;
            m_clr[d] = '0; m_led[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(o_ready[0]), 32'd0);
        check("rst_rdata", o_rdata[0], 32'd0);
        check("rst_err", 32'(o_err[1]), 32'd0);
        check("rst_led", 32'(led0), 32'd0);
        idle(1);

        // Zero-wait LED write through a non-zero base address
        xfer(0, 1'b1, 32'h0000_0010, 32'h0000_A5A5, rd);
        check("t1_led", 32'(led0), 32'h0000_A5A5);

        // Switch visibility and edge capture (back-to-back reads)
        sw_in = 16'h00F0;
        idle(3);
        xfer(0, 1'b0, 32'h0000_0004, 32'h0, rd);
        check("t2_sw", rd, 32'h0000_00F0);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0, rd);
        check("t2_edge", rd, 32'h0000_00F0);

        // W1C, then a new rise on bit 4 coinciding with its clear
        xfer(0, 1'b1, 32'h0000_0008, 32'h0000_0030, rd);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0, rd);
        check("t3_w1c", rd, 32'h0000_00C0);
        sw_in = 16'h00E0;
        idle(5);
        sw_in = 16'h00F0;
        idle(1);
        xfer(0, 1'b1, 32'h0000_0008, 32'h0000_0010, rd);
        idle(1);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0, rd);
        check("t3_set_wins", rd, 32'h0000_00D0);

        // Three wait states
        xfer(1, 1'b1, 32'h0000_0000, 32'h0000_A5A5, rd);
        xfer(1, 1'b0, 32'h0000_0000, 32'h0, rd);
        check("t4_rd", rd, 32'h0000_A5A5);

        // Reserved offset and write to the read-only switch register
        xfer(0, 1'b0, 32'h0000_000C, 32'h0, rd);
        check("t5_rsv0", rd, 32'h0);
        xfer(1, 1'b0, 32'h0000_000C, 32'h0, rd);
        check("t5_rsv3", rd, 32'h0);
        xfer(0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, rd);
        xfer(0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, rd);

        // Abort: deselect during the wait states, nothing is written
        t_sel[1] = 1'b1; t_en[1] = 1'b0; t_wr[1] = 1'b1;
        t_addr[1] = 32'h0; t_wdata[1] = 32'h0000_1234;
        @(posedge clk); #1;
        t_en[1] = 1'b1;
        @(posedge clk); #1;
        check("abort_wait", 32'(o_ready[1]), 32'd0);
        t_sel[1] = 1'b0; t_en[1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | o_ready[1];
        end
        check("abort_noready", 32'(seen), 32'd0);
        check("abort_led", 32'(led3), 32'h0000_A5A5);

        // Randomized traffic on both instances
        for (int k = 0; k < 80; k++) begin
            int  d;
            bit  wr;
            if ($urandom_range(0, 3) == 0) sw_in = N'($urandom);
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            xfer(d, wr, $urandom & 32'hFFFF_FFFC, $urandom, rd);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a waited write
        t_sel[1] = 1'b1; t_en[1] = 1'b0; t_wr[1] = 1'b1;
        t_addr[1] = 32'h0; t_wdata[1] = 32'h0000_5A5A;
        @(posedge clk); #1;
        t_en[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            t_sel[d] = 1'b0; t_en[d] = 1'b0; m_led[d] = '0; m_clr[d] = '0;
        end
        #1;
        check("t6_ready", 32'(o_ready[1]), 32'd0);
        check("t6_led", 32'(led3), 32'd0);
        check("t6_rdata", o_rdata[1], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        xfer(1, 1'b0, 32'h0000_0000, 32'h0, rd);
        check("t6_not_committed", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
